ixc_mdr_drive_seq: RTL

- Downstream consumer of the driver-on edge detector. Takes its one-cycle change pulse (drOn) plus the current enable level (en).
- Produces a contention-safe pad output-enable with programmable dead-time: break-before-make on turn-off, delayed make on turn-on.
- Logs every real oe transition into a single-entry record register with valid/ack handshake toward the emulation trace collector.
- Counts aborted (glitch) enables.

---
 rtl/ixc_mdr_drive_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ixc_mdr_drive_seq.sv
// ============================================================================
// Module   : ixc_mdr_drive_seq
// Purpose  : Dead-time sequenced pad output-enable driven by driver-on change
//            pulses, with an oe-edge trace record and a glitch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ixc_mdr_drive_seq #(
    parameter int DEAD_CYC = 2,
    parameter int TSW      = 16,
    parameter int GLW      = 8
) (
    input  logic           fclk,
    input  logic           rstN,
    input  logic           drOn,
    input  logic           en,
    output logic           oe,
    output logic           busy,
    output logic           evtVld,
    output logic [TSW:0]   evtDat,
    input  logic           evtAck,
    output logic           evtOvf,
    output logic [GLW-1:0] glitchCnt
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_DEAD_ON  = 2'd1,
        ST_ON       = 2'd2,
        ST_DEAD_OFF = 2'd3
    } state_t;

    localparam logic [3:0] c_DEAD_LOAD = (DEAD_CYC > 0) ? 4'(DEAD_CYC - 1) : 4'd0;
    localparam bit         c_NO_DEAD   = (DEAD_CYC == 0);

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_oe;
    logic           r_busy;
    logic [TSW-1:0] r_ts;
    logic           r_evtVld;
    logic [TSW:0]   r_evtDat;
    logic           r_evtOvf;
    logic [GLW-1:0] r_glitchCnt;

    state_t         w_stateNext;
    logic [3:0]     w_cntNext;
    logic           w_oeNext;
    logic           w_glitchInc;
    logic           w_rise;
    logic           w_fall;
    logic           w_oeEdge;
    logic [TSW-1:0] w_tsNext;

    assign w_rise   = drOn && en;
    assign w_fall   = drOn && !en;
    assign w_tsNext = r_ts + TSW'(1);
    assign w_oeEdge = (w_oeNext != r_oe);

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_oeNext    = r_oe;
        w_glitchInc = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_rise) begin
                    if (c_NO_DEAD) begin
                        w_stateNext = ST_ON;
                        w_oeNext    = 1'b1;
                    end else begin
                        w_stateNext = ST_DEAD_ON;
                        w_cntNext   = c_DEAD_LOAD;
                    end
                end
            end
            ST_DEAD_ON: begin
                // An enable withdrawn before the dead time elapses is a glitch.
                if (w_fall) begin
                    w_stateNext = ST_OFF;
                    w_glitchInc = 1'b1;
                end else if (r_cnt == 4'd0) begin
                    w_stateNext = ST_ON;
                    w_oeNext    = 1'b1;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ST_ON: begin
                if (w_fall) begin
                    w_oeNext = 1'b0;
                    if (c_NO_DEAD) begin
                        w_stateNext = ST_OFF;
                    end else begin
                        w_stateNext = ST_DEAD_OFF;
                        w_cntNext   = c_DEAD_LOAD;
                    end
                end
            end
            ST_DEAD_OFF: begin
                // Re-enable restarts the full dead time; elapsed hold-off earns no credit.
                if (w_rise) begin
                    w_stateNext = ST_DEAD_ON;
                    w_cntNext   = c_DEAD_LOAD;
                end else if (r_cnt == 4'd0) begin
                    w_stateNext = ST_OFF;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            default: begin
                w_stateNext = ST_OFF;
                w_oeNext    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= ST_OFF;
            r_cnt       <= 4'd0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_ts        <= '0;
            r_glitchCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_oe    <= w_oeNext;
            r_busy  <= (w_stateNext == ST_DEAD_ON) || (w_stateNext == ST_DEAD_OFF);
            r_ts    <= w_tsNext;
            if (w_glitchInc && (r_glitchCnt != {GLW{1'b1}})) begin
                r_glitchCnt <= r_glitchCnt + GLW'(1);
            end
        end
    end

    // The record timestamp is the counter value in the first cycle oe shows its new level.
    always_ff @(posedge fclk or negedge rstN) begin
        if (!rstN) begin
            r_evtVld <= 1'b0;
            r_evtDat <= '0;
            r_evtOvf <= 1'b0;
        end else if (w_oeEdge) begin
            if (!r_evtVld || evtAck) begin
                r_evtVld <= 1'b1;
                r_evtDat <= {w_oeNext, w_tsNext};
            end else begin
                r_evtOvf <= 1'b1;
            end
        end else if (evtAck) begin
            r_evtVld <= 1'b0;
        end
    end

    assign oe        = r_oe;
    assign busy      = r_busy;
    assign evtVld    = r_evtVld;
    assign evtDat    = r_evtDat;
    assign evtOvf    = r_evtOvf;
    assign glitchCnt = r_glitchCnt;

endmodule

`default_nettype wire
